// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// and a two-stage pipeline produces one edge magnitude per interior pixel.
module sobel_edge_filter #(
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned THRESH = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       valid_i,
  input  logic [7:0] GrayColor_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [7:0] EdgeColor_o,
  output logic       done_o
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned PIX_W = 8;
  localparam int unsigned SUM_W = 10;
  localparam int unsigned MAG_W = 11;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e             state, state_next;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               flush_cnt;
  logic               accept_c, last_c, qual_c;
  logic [PIX_W-1:0]   lb0 [IMG_W];
  logic [PIX_W-1:0]   lb1 [IMG_W];
  logic [2:0][2:0][PIX_W-1:0] win;
  logic               s1_valid, s1_last, s2_valid, s2_last;
  logic [PIX_W-1:0]   s2_pix;

  logic [SUM_W-1:0]        gx_p, gx_n, gy_p, gy_n;
  logic signed [MAG_W-1:0] gx, gy;
  logic [MAG_W-1:0]        ax, ay, mag;
  logic [PIX_W-1:0]        edge_c;

  assign last_c = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign qual_c = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Next-state logic; start_i always wins and (re)enters RUN
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = RUN;
      end
      RUN: begin
        if (start_i) begin
          state_next = RUN;
        end else if (valid_i) begin
          accept_c = 1'b1;
          if (last_c) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (start_i)        state_next = RUN;
        else if (flush_cnt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy_o stays high through the second FLUSH cycle so it falls after done_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      busy_o    <= (state_next != IDLE) || (state == FLUSH);
      flush_cnt <= (state == FLUSH) && !flush_cnt && !start_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col <= '0;
      row <= '0;
    end else if (start_i) begin
      col <= '0;
      row <= '0;
    end else if (accept_c) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= last_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffers: column col holds the two previous rows at that column
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      lb1[col] <= lb0[col];
      lb0[col] <= GrayColor_i;
    end
  end

  always_comb begin
    gx_p = SUM_W'(win[0][2]) + SUM_W'({win[1][2], 1'b0}) + SUM_W'(win[2][2]);
    gx_n = SUM_W'(win[0][0]) + SUM_W'({win[1][0], 1'b0}) + SUM_W'(win[2][0]);
    gy_p = SUM_W'(win[2][0]) + SUM_W'({win[2][1], 1'b0}) + SUM_W'(win[2][2]);
    gy_n = SUM_W'(win[0][0]) + SUM_W'({win[0][1], 1'b0}) + SUM_W'(win[0][2]);
    gx   = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
    gy   = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
    ax   = gx[MAG_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
    ay   = gy[MAG_W-1] ? MAG_W'(-gy) : MAG_W'(gy);
    mag  = ax + ay;
    if (THRESH == 0) edge_c = (mag > MAG_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
    else             edge_c = (32'(mag) >= THRESH) ? 8'hFF : 8'h00;
  end

  // Window shift plus result pipeline; start_i drops anything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win         <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_pix      <= '0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
      EdgeColor_o <= '0;
    end else begin
      if (accept_c) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1[col];
        win[1][2] <= lb0[col];
        win[2][2] <= GrayColor_i;
      end
      if (start_i) begin
        s1_valid <= 1'b0;
        s1_last  <= 1'b0;
        s2_valid <= 1'b0;
        s2_last  <= 1'b0;
        valid_o  <= 1'b0;
        done_o   <= 1'b0;
      end else begin
        s1_valid <= accept_c && qual_c;
        s1_last  <= accept_c && last_c;
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        valid_o  <= s2_valid;
        done_o   <= s2_valid && s2_last;
      end
      if (s1_valid) s2_pix <= edge_c;
      if (s2_valid) EdgeColor_o <= s2_pix;
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter: two instances (THRESH 0 and 300)
// share one stimulus stream and are checked against a frame-level Sobel model.
module tb_sobel_edge_filter;
  localparam int W = 5;
  localparam int H = 5;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       start_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] GrayColor_i = 8'h00;
  logic       busy0, valid0, done0, busy1, valid1, done1;
  logic [7:0] edge0, edge1;

  sobel_edge_filter #(.IMG_W(W), .IMG_H(H), .THRESH(0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i),
    .GrayColor_i(GrayColor_i), .busy_o(busy0), .valid_o(valid0),
    .EdgeColor_o(edge0), .done_o(done0));

  sobel_edge_filter #(.IMG_W(W), .IMG_H(H), .THRESH(300)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i),
    .GrayColor_i(GrayColor_i), .busy_o(busy1), .valid_o(valid1),
    .EdgeColor_o(edge1), .done_o(done1));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int e0;
    int e1;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   img[H][W];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sobel magnitude centred on image pixel (r,c), then the output law for th
  function automatic int sobel(input int r, input int c, input int th);
    int gx, gy, mag;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (th == 0) return (mag > 255) ? 255 : mag;
    return (mag >= th) ? 255 : 0;
  endfunction

  // Monitor: every presented result must match the oldest pending expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      chk("done0_implies_valid", int'(done0 & ~valid0), 0);
      chk("done1_implies_valid", int'(done1 & ~valid1), 0);
      if (valid0 || valid1) begin
        chk("result_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("valid_t0", int'(valid0), 1);
          chk("valid_t300", int'(valid1), 1);
          chk("edge_t0", int'(edge0), e.e0);
          chk("edge_t300", int'(edge1), e.e1);
          chk("done_t0", int'(done0), int'(e.last));
          chk("done_t300", int'(done1), int'(e.last));
          chk("latency_cycle", cyc, e.cyc);
          if (e.last) chk("busy_at_done", int'(busy0 & busy1), 1);
        end
      end else if (q.size() > 0) begin
        chk("result_overdue", int'(q[0].cyc <= cyc), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_valid0", int'(valid0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_edge0", int'(edge0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_valid1", int'(valid1), 0);
  endtask

  // mode 0 flat 0xEE, 1 vertical step, 2 horizontal ramp, 3 random
  task automatic gen_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'hEE;
          1:       img[r][c] = (c >= 2) ? 100 : 0;
          2:       img[r][c] = 10 * c;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // Start pulse carries a simultaneous pixel that must be ignored
  task automatic do_start();
    start_i     = 1'b1;
    valid_i     = 1'b1;
    GrayColor_i = 8'($urandom);
    step();
    start_i = 1'b0;
    valid_i = 1'b0;
    q.delete();
    chk("busy_after_start", int'(busy0 & busy1), 1);
  endtask

  // gap: 0 none, 1 every other cycle, 2 random; stop_kind 1 reset, 2 leave for restart
  task automatic send_frame(input int gap, input int stop_after, input int stop_kind);
    exp_t e;
    int   r, c, budget;
    do_start();
    for (int n = 0; n < W*H; n++) begin
      if (n == stop_after) begin
        if (stop_kind == 1) begin
          rst_ni = 1'b0;
          q.delete();
          step();
          check_reset_outputs();
          step();
          rst_ni = 1'b1;
          step();
          check_reset_outputs();
        end
        return;
      end
      if (gap == 1 && n > 0) begin
        GrayColor_i = 8'($urandom);
        step();
      end else if (gap == 2) begin
        repeat ($urandom_range(0, 2)) begin
          GrayColor_i = 8'($urandom);
          step();
        end
      end
      r = n / W;
      c = n % W;
      valid_i     = 1'b1;
      GrayColor_i = 8'(img[r][c]);
      if (r >= 2 && c >= 2) begin
        e.e0   = sobel(r - 1, c - 1, 0);
        e.e1   = sobel(r - 1, c - 1, 300);
        e.last = (r == H - 1) && (c == W - 1);
        e.cyc  = cyc + 3;
        q.push_back(e);
      end
      step();
      valid_i = 1'b0;
    end
    budget = 0;
    while (q.size() > 0 && budget < 40) begin
      step();
      budget++;
    end
    chk("drain_timeout", q.size(), 0);
    chk("busy_fall0", int'(busy0), 0);
    chk("busy_fall1", int'(busy1), 0);
  endtask

  task automatic idle_pixels(input int n);
    repeat (n) begin
      valid_i     = 1'b1;
      GrayColor_i = 8'($urandom);
      step();
      chk("idle_busy0", int'(busy0), 0);
      chk("idle_busy1", int'(busy1), 0);
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_ni = 1'b1;
    step();

    idle_pixels(5);

    gen_img(0); send_frame(0, -1, 0);
    gen_img(1); send_frame(0, -1, 0);
    gen_img(2); send_frame(0, -1, 0);
    gen_img(1); send_frame(1, -1, 0);

    gen_img(3); send_frame(0, 12, 1);
    send_frame(0, -1, 0);
    gen_img(3); send_frame(2, 14, 2);
    send_frame(0, -1, 0);

    repeat (6) begin
      gen_img(3);
      send_frame(2, -1, 0);
    end

    idle_pixels(6);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
